// File: rtl/sti_dac_gen_if.sv
// rtl/sti_dac_gen_if.sv - frame request, serial stream and byte-write port bundle for sti_dac_gen
interface sti_dac_gen_if #(
  parameter int DATA_W = 16,
  parameter int NBANK  = 4,
  parameter int ADDR_W = 5
);
  logic              load;
  logic [DATA_W-1:0] pi_data;
  logic [1:0]        pi_length;
  logic              pi_fill;
  logic              pi_msb;
  logic              pi_low;
  logic              pi_end;
  logic              so_ready;
  logic              busy;
  logic              so_data;
  logic              so_valid;
  logic [7:0]        oem_dataout;
  logic [ADDR_W-1:0] oem_addr;
  logic [NBANK-1:0]  odd_wr;
  logic [NBANK-1:0]  even_wr;
  logic              oem_finish;

  modport master (
    output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, so_ready,
    input  busy, so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish
  );

  modport slave (
    input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, so_ready,
    output busy, so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish
  );
endinterface

// File: rtl/sti_dac_gen.sv
// rtl/sti_dac_gen.sv - serial transmitter that also packs its bit stream into bytes
// scattered across NBANK odd/even memory pairs, with zero-fill on end of stream.
module sti_dac_gen #(
  parameter int DATA_W    = 16,
  parameter int NBANK     = 4,
  parameter int ADDR_W    = 5,
  parameter int ROW_BYTES = 8
) (
  input logic          clk,
  input logic          reset,
  sti_dac_gen_if.slave bus
);
  localparam int TOTAL  = NBANK * 2 * (2 ** ADDR_W);
  localparam int K_W    = $clog2(TOTAL) + 1;
  localparam int FW     = 2 * DATA_W;
  localparam int LEN_W  = $clog2(FW + 1);
  localparam int HALF   = DATA_W / 2;
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int ROW_SH = $clog2(ROW_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FILL, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [FW-1:0]     r_sh;
  logic              r_msb;
  logic [LEN_W-1:0]  r_left;
  logic [7:0]        r_acc;
  logic [2:0]        r_bitcnt;
  logic [K_W-1:0]    r_k;
  logic [7:0]        r_dout;
  logic [ADDR_W-1:0] r_addr;
  logic [NBANK-1:0]  r_odd;
  logic [NBANK-1:0]  r_even;
  logic              r_finish;

  logic              w_capture;
  logic              w_fill_wr;
  logic              w_xfer;
  logic              w_bit;
  logic              w_ser_wr;
  logic              w_wr_en;
  logic              w_k_valid;
  logic              w_last_k;
  logic              w_odd;
  logic [7:0]        w_acc_next;
  logic [7:0]        w_wr_byte;
  logic [ADDR_W-1:0] w_addr;
  logic [BANK_W-1:0] w_bank;
  logic [NBANK-1:0]  w_onehot;
  logic [FW-1:0]     w_frame;
  logic [FW-1:0]     w_aligned;
  logic [LEN_W-1:0]  w_len;

  // Frame is built right-aligned; MSB-first frames are then left-aligned so the
  // outgoing bit is always at one end of the shifter.
  always_comb begin
    w_frame = '0;
    w_len   = '0;
    case (bus.pi_length)
      2'b00: begin
        w_len = LEN_W'(HALF);
        w_frame[HALF-1:0] = bus.pi_low ? bus.pi_data[DATA_W-1:HALF] : bus.pi_data[HALF-1:0];
      end
      2'b01: begin
        w_len = LEN_W'(DATA_W);
        w_frame[DATA_W-1:0] = bus.pi_data;
      end
      2'b10: begin
        w_len = LEN_W'(DATA_W + HALF);
        if (bus.pi_fill) w_frame[DATA_W+HALF-1:HALF] = bus.pi_data;
        else             w_frame[DATA_W-1:0]         = bus.pi_data;
      end
      default: begin
        w_len = LEN_W'(FW);
        if (bus.pi_fill) w_frame[FW-1:DATA_W] = bus.pi_data;
        else             w_frame[DATA_W-1:0]  = bus.pi_data;
      end
    endcase
    w_aligned = bus.pi_msb ? (w_frame << (LEN_W'(FW) - w_len)) : w_frame;
  end

  assign w_bit      = r_msb ? r_sh[FW-1] : r_sh[0];
  assign w_xfer     = (r_state == S_SHIFT) && bus.so_ready;
  assign w_acc_next = {r_acc[6:0], w_bit};
  assign w_ser_wr   = w_xfer && (r_bitcnt == 3'd7);
  assign w_k_valid  = r_k < K_W'(TOTAL);
  assign w_last_k   = r_k == K_W'(TOTAL - 1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Fill writes are issued from the IDLE cycle that samples pi_end, so they never
  // share a cycle with a serial byte completion.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_fill_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load) begin
          w_capture = 1'b1;
          w_next    = S_SHIFT;
        end else if (bus.pi_end) begin
          if (w_k_valid) begin
            w_fill_wr = 1'b1;
            w_next    = w_last_k ? S_DONE : S_FILL;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        if (w_xfer && (r_left == LEN_W'(1))) w_next = S_IDLE;
      end
      S_FILL: begin
        if (w_k_valid) begin
          w_fill_wr = 1'b1;
          if (w_last_k) w_next = S_DONE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = r_state;
    endcase
  end

  assign w_wr_en   = (w_ser_wr || w_fill_wr) && w_k_valid;
  assign w_wr_byte = w_fill_wr ? 8'h00 : w_acc_next;
  assign w_addr    = r_k[ADDR_W:1];
  assign w_bank    = BANK_W'(r_k >> (ADDR_W + 1)) & BANK_W'(NBANK - 1);
  assign w_onehot  = NBANK'(1) << w_bank;
  assign w_odd     = ~(r_k[0] ^ r_k[ROW_SH]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh     <= '0;
      r_msb    <= 1'b0;
      r_left   <= '0;
      r_acc    <= '0;
      r_bitcnt <= '0;
      r_k      <= '0;
      r_dout   <= '0;
      r_addr   <= '0;
      r_odd    <= '0;
      r_even   <= '0;
      r_finish <= 1'b0;
    end else begin
      if (w_capture) begin
        r_sh   <= w_aligned;
        r_msb  <= bus.pi_msb;
        r_left <= w_len;
      end else if (w_xfer) begin
        r_sh     <= r_msb ? (r_sh << 1) : (r_sh >> 1);
        r_left   <= r_left - LEN_W'(1);
        r_acc    <= w_acc_next;
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      // k saturates at TOTAL so overflow bytes are dropped without wrapping.
      if (w_wr_en) r_k <= r_k + K_W'(1);
      r_odd  <= '0;
      r_even <= '0;
      if (w_wr_en) begin
        r_dout <= w_wr_byte;
        r_addr <= w_addr;
        if (w_odd) r_odd  <= w_onehot;
        else       r_even <= w_onehot;
      end
      r_finish <= (r_state == S_DONE);
    end
  end

  assign bus.busy        = (r_state == S_SHIFT);
  assign bus.so_valid    = (r_state == S_SHIFT);
  assign bus.so_data     = w_bit;
  assign bus.oem_dataout = r_dout;
  assign bus.oem_addr    = r_addr;
  assign bus.odd_wr      = r_odd;
  assign bus.even_wr     = r_even;
  assign bus.oem_finish  = r_finish;
endmodule

// File: tb/tb_sti_dac_gen.sv
// tb/tb_sti_dac_gen.sv - self-checking bench for sti_dac_gen: vector table, corner sequences
// and randomized frames against a bit-stream/byte-placement reference model.
module tb_sti_dac_gen;
  localparam int DATA_W    = 16;
  localparam int NBANK     = 4;
  localparam int ADDR_W    = 5;
  localparam int ROW_BYTES = 8;
  localparam int TOTAL     = NBANK * 2 * (1 << ADDR_W);

  typedef struct {
    int         bank;
    bit         odd;
    int         addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  len;
    bit          fill;
    bit          msb;
    bit          low;
    int          nbits;
    logic [31:0] stream;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sti_dac_gen_if #(.DATA_W(DATA_W), .NBANK(NBANK), .ADDR_W(ADDR_W)) bus ();

  sti_dac_gen #(.DATA_W(DATA_W), .NBANK(NBANK), .ADDR_W(ADDR_W), .ROW_BYTES(ROW_BYTES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   n_err = 0;
  int   n_checks = 0;
  int   cyc_n = 0;
  bit   fin_seen = 0;
  int   fin_cyc = 0;
  bit   obs_bits[$];
  wr_t  obs_w[$];
  bit   exp_bits[$];
  wr_t  exp_w[$];
  wr_t  mw;
  int   m_k;
  int   m_n;
  logic [7:0] m_acc;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (reset) begin
      fin_seen = 0;
    end else begin
      if (bus.so_valid && bus.so_ready) obs_bits.push_back(bus.so_data);
      if ((bus.odd_wr | bus.even_wr) != '0) begin
        n_checks++;
        if ($countones({bus.odd_wr, bus.even_wr}) != 1) begin
          n_err++;
          $display("FAIL strobe_onehot: got odd=%b even=%b, required exactly one bit", bus.odd_wr, bus.even_wr);
        end
        for (int b = 0; b < NBANK; b++) if (bus.odd_wr[b] || bus.even_wr[b]) mw.bank = b;
        mw.odd  = (bus.odd_wr != '0);
        mw.addr = int'(bus.oem_addr);
        mw.data = bus.oem_dataout;
        mw.cyc  = cyc_n;
        obs_w.push_back(mw);
      end
      if (bus.oem_finish && !fin_seen) begin
        fin_seen = 1;
        fin_cyc  = cyc_n;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wr_t place(input int k, input logic [7:0] d);
    wr_t w;
    w.bank = (k / (2 * (1 << ADDR_W))) % NBANK;
    w.addr = (k / 2) % (1 << ADDR_W);
    w.odd  = (((k % 2) ^ ((k / ROW_BYTES) % 2)) == 0);
    w.data = d;
    w.cyc  = 0;
    return w;
  endfunction

  task automatic model_byte(input logic [7:0] d);
    if (m_k < TOTAL) exp_w.push_back(place(m_k, d));
    m_k++;
  endtask

  task automatic model_frame(input logic [15:0] d, input logic [1:0] len, input bit fill, input bit msb, input bit low);
    int L;
    logic [31:0] f;
    bit b;
    L = (DATA_W / 2) * (int'(len) + 1);
    case (len)
      2'd0:    f = low ? 32'(d >> 8) : 32'(d & 16'h00FF);
      2'd1:    f = 32'(d);
      2'd2:    f = fill ? (32'(d) << 8) : 32'(d);
      default: f = fill ? (32'(d) << 16) : 32'(d);
    endcase
    for (int i = 0; i < L; i++) begin
      b = msb ? f[L-1-i] : f[i];
      exp_bits.push_back(b);
      m_acc = {m_acc[6:0], b};
      m_n++;
      if (m_n == 8) begin
        m_n = 0;
        model_byte(m_acc);
      end
    end
  endtask

  task automatic model_fill();
    while (m_k < TOTAL) model_byte(8'h00);
  endtask

  task automatic compare_streams(input string tag);
    int nb;
    int nw;
    check({tag, " bit_count"}, obs_bits.size(), exp_bits.size());
    nb = (obs_bits.size() < exp_bits.size()) ? obs_bits.size() : exp_bits.size();
    for (int i = 0; i < nb; i++) check($sformatf("%s bit[%0d]", tag, i), obs_bits[i], exp_bits[i]);
    check({tag, " write_count"}, obs_w.size(), exp_w.size());
    nw = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < nw; i++) begin
      check($sformatf("%s wr[%0d] data", tag, i), obs_w[i].data, exp_w[i].data);
      check($sformatf("%s wr[%0d] bank", tag, i), obs_w[i].bank, exp_w[i].bank);
      check($sformatf("%s wr[%0d] odd", tag, i), obs_w[i].odd, exp_w[i].odd);
      check($sformatf("%s wr[%0d] addr", tag, i), obs_w[i].addr, exp_w[i].addr);
    end
    obs_bits.delete();
    obs_w.delete();
    exp_bits.delete();
    exp_w.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.load = 1'b0;
    bus.pi_end = 1'b0;
    bus.so_ready = 1'b1;
    tick();
    tick();
    check("reset busy", bus.busy, 0);
    check("reset so_valid", bus.so_valid, 0);
    check("reset so_data", bus.so_data, 0);
    check("reset strobes", {bus.odd_wr, bus.even_wr}, 0);
    check("reset dataout_addr", {bus.oem_dataout, bus.oem_addr}, 0);
    check("reset finish", bus.oem_finish, 0);
    reset = 1'b0;
    obs_bits.delete();
    obs_w.delete();
    exp_bits.delete();
    exp_w.delete();
    m_k = 0;
    m_n = 0;
    m_acc = '0;
  endtask

  task automatic send_frame(input logic [15:0] d, input logic [1:0] len, input bit fill, input bit msb,
                            input bit low, input bit endreq, input int mode, output int vcyc);
    bus.pi_data = d;
    bus.pi_length = len;
    bus.pi_fill = fill;
    bus.pi_msb = msb;
    bus.pi_low = low;
    bus.pi_end = endreq;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.pi_end = 1'b0;
    check("busy after load", bus.busy, 1);
    check("so_valid after load", bus.so_valid, 1);
    vcyc = 0;
    while (bus.busy && vcyc < 300) begin
      case (mode)
        1:       bus.so_ready = ($urandom_range(0, 2) != 0);
        2:       bus.so_ready = !(vcyc >= 5 && vcyc <= 7);
        default: bus.so_ready = 1'b1;
      endcase
      if (mode == 2 && vcyc >= 5 && vcyc <= 7) check("so_data frozen in stall", bus.so_data, 1);
      tick();
      vcyc++;
    end
    bus.so_ready = 1'b1;
    if (bus.busy) begin
      n_checks++;
      n_err++;
      $display("FAIL frame_timeout: busy still 1 after %0d cycles, required 0", vcyc);
    end
  endtask

  task automatic wait_finish();
    int n = 0;
    while (!fin_seen && n < 400) begin
      tick();
      n++;
    end
    check("finish reached", fin_seen, 1);
  endtask

  vec_t vt[7];

  initial begin
    int vc;
    int pe_cyc;
    int gaps;
    logic [31:0] v;
    logic [15:0] rd;
    logic [1:0]  rl;
    bit rf, rm, rlow, re;

    bus.load = 1'b0;
    bus.pi_data = '0;
    bus.pi_length = '0;
    bus.pi_fill = 1'b0;
    bus.pi_msb = 1'b0;
    bus.pi_low = 1'b0;
    bus.pi_end = 1'b0;
    bus.so_ready = 1'b1;

    vt[0] = '{16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0, 16, 32'h0000A5C3};
    vt[1] = '{16'h8001, 2'b00, 1'b0, 1'b0, 1'b1, 8,  32'h00000001};
    vt[2] = '{16'hFFFF, 2'b10, 1'b1, 1'b1, 1'b0, 24, 32'h00FFFF00};
    vt[3] = '{16'hFFFF, 2'b10, 1'b0, 1'b1, 1'b0, 24, 32'h0000FFFF};
    vt[4] = '{16'h1234, 2'b01, 1'b0, 1'b0, 1'b0, 16, 32'h00002C48};
    vt[5] = '{16'hC0DE, 2'b11, 1'b0, 1'b0, 1'b0, 32, 32'h7B030000};
    vt[6] = '{16'h3C5A, 2'b00, 1'b0, 1'b1, 1'b0, 8,  32'h0000005A};

    do_reset();
    foreach (vt[i]) begin
      model_frame(vt[i].data, vt[i].len, vt[i].fill, vt[i].msb, vt[i].low);
      send_frame(vt[i].data, vt[i].len, vt[i].fill, vt[i].msb, vt[i].low, 1'b0, 0, vc);
      tick();
      check($sformatf("vec%0d nbits", i), obs_bits.size(), vt[i].nbits);
      v = '0;
      foreach (obs_bits[j]) v = {v[30:0], obs_bits[j]};
      check($sformatf("vec%0d stream", i), v, vt[i].stream);
      compare_streams($sformatf("vec%0d", i));
    end

    // Backpressure: 3-cycle stall mid-frame stretches valid to 19 cycles.
    model_frame(16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0);
    send_frame(16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2, vc);
    tick();
    check("stall valid cycles", vc, 19);
    compare_streams("stall");

    // Row flip across the 8-byte checkerboard row.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      model_frame(16'h0011, 2'b00, 1'b0, 1'b1, 1'b0);
      send_frame(16'h0011, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 0, vc);
    end
    tick();
    check("rowflip write count", obs_w.size(), 10);
    if (obs_w.size() >= 10) begin
      check("k8 even bank0", {obs_w[8].odd, 8'(obs_w[8].bank)}, {1'b0, 8'd0});
      check("k8 addr", obs_w[8].addr, 4);
      check("k9 odd bank0", {obs_w[9].odd, 8'(obs_w[9].bank)}, {1'b1, 8'd0});
      check("k9 addr", obs_w[9].addr, 4);
      check("k9 data", obs_w[9].data, 8'h11);
    end
    compare_streams("rowflip");

    // End fill after two bytes.
    do_reset();
    model_frame(16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0);
    send_frame(16'hA5C3, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 0, vc);
    tick();
    check("fill pre writes", obs_w.size(), 2);
    if (obs_w.size() >= 2) begin
      check("first byte A5 odd0 addr0", {obs_w[0].data, obs_w[0].odd, 8'(obs_w[0].bank), 8'(obs_w[0].addr)},
            {8'hA5, 1'b1, 8'd0, 8'd0});
      check("second byte C3 even0 addr0", {obs_w[1].data, obs_w[1].odd, 8'(obs_w[1].bank), 8'(obs_w[1].addr)},
            {8'hC3, 1'b0, 8'd0, 8'd0});
    end
    compare_streams("fill pre");
    pe_cyc = cyc_n;
    bus.pi_end = 1'b1;
    tick();
    bus.pi_end = 1'b0;
    model_fill();
    wait_finish();
    check("fill strobe count", obs_w.size(), 254);
    if (obs_w.size() == 254) begin
      check("first fill cycle", obs_w[0].cyc, pe_cyc + 1);
      gaps = 0;
      for (int i = 1; i < 254; i++) if (obs_w[i].cyc != obs_w[i-1].cyc + 1) gaps++;
      check("fill strobes consecutive", gaps, 0);
      check("last fill odd3 addr31", {obs_w[253].odd, 8'(obs_w[253].bank), 8'(obs_w[253].addr)},
            {1'b1, 8'd3, 8'd31});
      check("finish after last fill", fin_cyc, obs_w[253].cyc + 1);
    end
    compare_streams("fill");
    bus.pi_data = 16'hFFFF;
    bus.pi_length = 2'b01;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    check("done ignores load busy", bus.busy, 0);
    check("done ignores load strobes", obs_w.size(), 0);
    check("finish held", bus.oem_finish, 1);

    // Reset mid-frame aborts without further strobes.
    do_reset();
    bus.pi_data = 16'hA5C3;
    bus.pi_length = 2'b01;
    bus.pi_msb = 1'b1;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    obs_w.delete();
    obs_bits.delete();
    for (int i = 0; i < 20; i++) tick();
    check("abort no strobes", obs_w.size(), 0);
    check("abort busy", bus.busy, 0);

    // Randomized frames under random backpressure, load winning over pi_end.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rd = 16'($urandom);
      rl = 2'($urandom_range(0, 3));
      rf = 1'($urandom);
      rm = 1'($urandom);
      rlow = 1'($urandom);
      re = ($urandom_range(0, 4) == 0);
      model_frame(rd, rl, rf, rm, rlow);
      send_frame(rd, rl, rf, rm, rlow, re, 1, vc);
    end
    tick();
    compare_streams("rand");
    bus.pi_end = 1'b1;
    tick();
    bus.pi_end = 1'b0;
    model_fill();
    wait_finish();
    if (obs_w.size() > 0) check("rand finish timing", fin_cyc, obs_w[obs_w.size()-1].cyc + 1);
    compare_streams("rand fill");

    // Fill every location serially, then overflow; pi_end goes straight to DONE.
    do_reset();
    for (int i = 0; i < 65; i++) begin
      rd = 16'($urandom);
      model_frame(rd, 2'b11, 1'b0, 1'b1, 1'b0);
      send_frame(rd, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 0, vc);
    end
    tick();
    compare_streams("full");
    pe_cyc = cyc_n;
    bus.pi_end = 1'b1;
    tick();
    bus.pi_end = 1'b0;
    wait_finish();
    check("full finish timing", fin_cyc, pe_cyc + 2);
    check("full no fill strobes", obs_w.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
